// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants and FSM state encoding for the mux scan controller.
`default_nettype none

package mux_scan_pkg;

  localparam int NUM_CH = 31;
  localparam int SEL_W  = 5;
  localparam int DATA_W = 2;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mux_scan_ctrl_if.sv
// Mux select/data pair plus the (channel, data) valid/ready sample stream.
`default_nettype none

interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic [SEL_W-1:0]  sel_o;
  logic [DATA_W-1:0] mux_i;
  logic              valid_o;
  logic              ready_i;
  logic [SEL_W-1:0]  ch_o;
  logic [DATA_W-1:0] data_o;

  modport master (
    output sel_o, valid_o, ch_o, data_o,
    input  mux_i, ready_i
  );

  modport slave (
    input  sel_o, valid_o, ch_o, data_o,
    output mux_i, ready_i
  );

endinterface

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// Sweeps the mux select over enabled channels and streams each sample out under valid/ready.
`default_nettype none

module mux_scan_ctrl
  import mux_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_en,
  mux_scan_ctrl_if.master   bus,
  output logic              busy_o,
  output logic              done_o
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              w_sweep_end;
  logic              w_last;

  assign w_last = (sel_q == LAST_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      mask_q  <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    mask_d      = mask_q;
    ch_d        = ch_q;
    data_d      = data_q;
    valid_d     = valid_q;
    w_sweep_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mask_d  = ch_en;
          sel_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (mask_q[sel_q]) begin
          data_d  = bus.mux_i;
          ch_d    = sel_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (!w_last) begin
          sel_d = sel_q + SEL_W'(1);
        end else begin
          w_sweep_end = 1'b1;
        end
      end
      HOLD: begin
        if (bus.ready_i) begin
          valid_d = 1'b0;
          if (!w_last) begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = SCAN;
          end else begin
            w_sweep_end = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // continuous is only looked at here, so a mid-sweep change lets the current sweep finish
    if (w_sweep_end) begin
      if (continuous) begin
        sel_d   = '0;
        mask_d  = ch_en;
        state_d = SCAN;
      end else begin
        state_d = DONE;
      end
    end

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      valid_d = 1'b0;
      sel_d   = '0;
    end
  end

  assign bus.sel_o   = sel_q;
  assign bus.valid_o = valid_q;
  assign bus.ch_o    = ch_q;
  assign bus.data_o  = data_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 31:1 x 2-bit mux on sel_o/mux_i.
`default_nettype none

module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic              continuous;
  logic [NUM_CH-1:0] ch_en;
  logic              busy_o;
  logic              done_o;

  logic [DATA_W-1:0] inp [NUM_CH];

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  mux_scan_ctrl_if bus ();

  mux_scan_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .continuous (continuous),
    .ch_en      (ch_en),
    .bus        (bus),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  assign bus.mux_i = inp[bus.sel_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done_o) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges until valid_o rises, bounded by budget.
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!bus.valid_o && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid_timeout", {31'd0, bus.valid_o}, 32'd1);
  endtask

  int n;
  int d0;
  logic seen_valid;

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    continuous = 1'b0;
    ch_en      = '0;
    bus.ready_i = 1'b0;
    for (int i = 0; i < NUM_CH; i++) inp[i] = DATA_W'(i % 4);

    tick();
    tick();
    check("rst_sel",   {27'd0, bus.sel_o}, 32'd0);
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_ch",    {27'd0, bus.ch_o}, 32'd0);
    check("rst_data",  {30'd0, bus.data_o}, 32'd0);
    check("rst_busy",  {31'd0, busy_o}, 32'd0);
    check("rst_done",  {31'd0, done_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Full sweep, every channel enabled, no backpressure
    ch_en = '1;
    bus.ready_i = 1'b1;
    d0 = done_cnt;
    pulse_start();
    check("full_busy", {31'd0, busy_o}, 32'd1);
    for (int k = 0; k < NUM_CH; k++) begin
      tick();
      check($sformatf("full_valid_%0d", k), {31'd0, bus.valid_o}, 32'd1);
      check($sformatf("full_ch_%0d", k),    {27'd0, bus.ch_o}, 32'(k));
      check($sformatf("full_data_%0d", k),  {30'd0, bus.data_o}, 32'(k % 4));
      check($sformatf("full_nodone_%0d", k), {31'd0, done_o}, 32'd0);
      tick();
    end
    check("full_done", {31'd0, done_o}, 32'd1);
    check("full_valid_low", {31'd0, bus.valid_o}, 32'd0);
    tick();
    check("full_done_once", {31'd0, done_o}, 32'd0);
    check("full_idle", {31'd0, busy_o}, 32'd0);
    check("full_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Sparse mask 0,2,30 with a 3-cycle stall on ch 2
    ch_en = 31'h4000_0005;
    pulse_start();
    tick();
    check("sp_ch0", {27'd0, bus.ch_o}, 32'd0);
    check("sp_ch0_valid", {31'd0, bus.valid_o}, 32'd1);
    tick();
    bus.ready_i = 1'b0;
    tick();
    tick();
    check("sp_ch2_valid", {31'd0, bus.valid_o}, 32'd1);
    check("sp_ch2_ch", {27'd0, bus.ch_o}, 32'd2);
    check("sp_ch2_data", {30'd0, bus.data_o}, 32'd2);
    inp[2] = 2'd1;
    ch_en  = '1;
    for (int s = 0; s < 3; s++) begin
      tick();
      check($sformatf("sp_stall_valid_%0d", s), {31'd0, bus.valid_o}, 32'd1);
      check($sformatf("sp_stall_ch_%0d", s),    {27'd0, bus.ch_o}, 32'd2);
      check($sformatf("sp_stall_data_%0d", s),  {30'd0, bus.data_o}, 32'd2);
      check($sformatf("sp_stall_sel_%0d", s),   {27'd0, bus.sel_o}, 32'd2);
    end
    inp[2] = 2'd2;
    bus.ready_i = 1'b1;
    tick();
    check("sp_hs_valid_low", {31'd0, bus.valid_o}, 32'd0);
    wait_valid(40, n);
    check("sp_gap_cycles", 32'(n), 32'd28);
    check("sp_ch30", {27'd0, bus.ch_o}, 32'd30);
    check("sp_ch30_data", {30'd0, bus.data_o}, 32'd2);
    tick();
    check("sp_done", {31'd0, done_o}, 32'd1);
    tick();
    check("sp_idle", {31'd0, busy_o}, 32'd0);

    // Empty mask: done 32 edges after (and counting) the start edge
    ch_en = '0;
    seen_valid = 1'b0;
    pulse_start();
    for (int e = 2; e <= 31; e++) begin
      tick();
      seen_valid |= bus.valid_o;
    end
    check("empty_nodone_31", {31'd0, done_o}, 32'd0);
    tick();
    seen_valid |= bus.valid_o;
    check("empty_done_32", {31'd0, done_o}, 32'd1);
    check("empty_no_valid", {31'd0, seen_valid}, 32'd0);
    tick();
    check("empty_idle", {31'd0, busy_o}, 32'd0);

    // Continuous sweep on ch 5, then drop continuous mid-sweep
    ch_en = 31'(1) << 5;
    continuous = 1'b1;
    d0 = done_cnt;
    pulse_start();
    wait_valid(20, n);
    check("cont_first_lat", 32'(n), 32'd6);
    check("cont_ch5_a", {27'd0, bus.ch_o}, 32'd5);
    check("cont_data5_a", {30'd0, bus.data_o}, 32'd1);
    tick();
    wait_valid(60, n);
    check("cont_ch5_b", {27'd0, bus.ch_o}, 32'd5);
    check("cont_no_done", 32'(done_cnt - d0), 32'd0);
    tick();
    continuous = 1'b0;
    n = 0;
    seen_valid = 1'b0;
    while (!done_o && n < 40) begin
      tick();
      seen_valid |= bus.valid_o;
      n++;
    end
    check("cont_stop_done", {31'd0, done_o}, 32'd1);
    check("cont_stop_cycles", 32'(n), 32'd25);
    check("cont_stop_no_valid", {31'd0, seen_valid}, 32'd0);
    tick();
    check("cont_stop_idle", {31'd0, busy_o}, 32'd0);

    // Abort while holding ch 7, then start/abort collision and restart
    ch_en = 31'h88;
    bus.ready_i = 1'b1;
    pulse_start();
    wait_valid(20, n);
    check("ab_ch3", {27'd0, bus.ch_o}, 32'd3);
    bus.ready_i = 1'b0;
    tick();
    check("ab_hold_ch3", {27'd0, bus.ch_o}, 32'd3);
    bus.ready_i = 1'b1;
    tick();
    wait_valid(20, n);
    check("ab_ch7", {27'd0, bus.ch_o}, 32'd7);
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_valid", {31'd0, bus.valid_o}, 32'd0);
    check("ab_busy", {31'd0, busy_o}, 32'd0);
    check("ab_sel", {27'd0, bus.sel_o}, 32'd0);
    check("ab_done", {31'd0, done_o}, 32'd0);
    tick();
    check("ab_no_done", 32'(done_cnt - d0), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("ab_collide_idle", {31'd0, busy_o}, 32'd0);
    pulse_start();
    wait_valid(20, n);
    check("ab_restart_lat", 32'(n), 32'd4);
    check("ab_restart_ch", {27'd0, bus.ch_o}, 32'd3);

    // Asynchronous reset while a sample is held
    bus.ready_i = 1'b0;
    tick();
    check("rs_pre_valid", {31'd0, bus.valid_o}, 32'd1);
    rst_n = 1'b0;
    #2;
    check("rs_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rs_sel",   {27'd0, bus.sel_o}, 32'd0);
    check("rs_ch",    {27'd0, bus.ch_o}, 32'd0);
    check("rs_data",  {30'd0, bus.data_o}, 32'd0);
    check("rs_busy",  {31'd0, busy_o}, 32'd0);
    check("rs_done",  {31'd0, done_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rs_post_busy", {31'd0, busy_o}, 32'd0);
    check("rs_post_valid", {31'd0, bus.valid_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
